// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a req/busy/ack handshake with a fixed response latency.
// Misaligned or out-of-range requests are acknowledged with err_o and never touch the array.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            ill_q, ill_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            in_ill;
    logic            commit;
    logic            c_we, c_ill;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;
    logic            mem_we;

    assign in_ill = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        ill_d   = ill_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        commit  = 1'b0;
        c_we    = we_q;
        c_ill   = ill_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    ill_d   = in_ill;
                    idx_d   = addr_i[AW+1:2];
                    wdata_d = wdata_i;
                    if (LATENCY == 1) begin
                        // Single-cycle latency commits on the accepting edge straight from the port.
                        state_d = RESP;
                        commit  = 1'b1;
                        c_we    = we_i;
                        c_ill   = in_ill;
                        c_idx   = addr_i[AW+1:2];
                        c_wdata = wdata_i;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            ack_d = 1'b1;
            err_d = c_ill;
            if (!c_we) rdata_d = c_ill ? 32'd0 : mem_q[c_idx];
        end
    end

    assign mem_we = commit && c_we && !c_ill;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_i) mem_q[c_idx] <= c_wdata;
    end

    assign busy_o  = (state_q != IDLE);
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: one instance at LATENCY=3 (index 0), one at LATENCY=1 (index 1),
// checked against a transaction-level model of memory contents and response timing.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        busy  [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem_m   [2][32];
    logic [31:0] prev_rd [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .busy_o(busy[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );
    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .busy_o(busy[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic bit is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32);
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
        int          L;
        bit          legal;
        logic [31:0] exp_rd;
        L     = lat(d);
        legal = is_legal(a);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        if (w) begin
            if (legal) mem_m[d][a[6:2]] = wd;
            exp_rd = prev_rd[d];
        end else begin
            exp_rd = legal ? mem_m[d][a[6:2]] : 32'd0;
        end
        prev_rd[d] = exp_rd;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (k == 1) req[d] = 1'b0;
            chk("busy", busy[d], 32'd1);
            chk("ack", ack[d], (k == L) ? 32'd1 : 32'd0);
            if (k == L) begin
                chk("err", err[d], legal ? 32'd0 : 32'd1);
                chk("rdata", rdata[d], exp_rd);
            end
        end
        @(negedge clk);
        chk("idle_busy", busy[d], 32'd0);
        chk("idle_ack", ack[d], 32'd0);
        chk("idle_err", err[d], 32'd0);
        chk("rdata_hold", rdata[d], exp_rd);
    endtask

    // req held high with a fresh random load address every cycle: one accept per LATENCY+1 cycles.
    task automatic hold(input int d);
        int          L, n, acks, j;
        bit          exp_ack;
        logic [31:0] A [16];
        logic [31:0] e;
        L = lat(d);
        n = 4 * (L + 1);
        acks = 0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                exp_ack = ((i % (L + 1)) == L);
                if (ack[d]) acks++;
                chk("hold_ack", ack[d], exp_ack ? 32'd1 : 32'd0);
                if (exp_ack) begin
                    j = i - L;
                    e = mem_m[d][A[j][6:2]];
                    prev_rd[d] = e;
                    chk("hold_rdata", rdata[d], e);
                    chk("hold_err", err[d], 32'd0);
                end
            end
            if (i < n) begin
                A[i] = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
                req[d] = 1'b1; we[d] = 1'b0; addr[d] = A[i];
                @(negedge clk);
            end else begin
                req[d] = 1'b0;
            end
        end
        chk("hold_count", acks, 32'd4);
        chk("hold_idle", busy[d], 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) return {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        if (sel < 8) return {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        return ($urandom | 32'h0000_0080) & 32'hFFFF_FFFC;
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; prev_rd[d] = 32'd0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 32'd0);
            chk("rst_ack", ack[d], 32'd0);
            chk("rst_err", err[d], 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Give every word a known value.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++) txn(d, 1'b1, 32'(w * 4), 32'd0);

        // Directed, LATENCY=3.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h10, 32'h0);
        txn(0, 1'b0, 32'h13, 32'h0);
        txn(0, 1'b1, 32'h12, 32'h1);
        txn(0, 1'b0, 32'h10, 32'h0);
        txn(0, 1'b1, 32'h80, 32'hFFFF_FFFF);
        txn(0, 1'b0, 32'h00, 32'h0);
        hold(0);

        // Reset during WAIT of a store to 0x20.
        txn(0, 1'b1, 32'h20, 32'h0);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        @(negedge clk);
        req[0] = 1'b0;
        chk("pre_rst_busy", busy[0], 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_busy", busy[d], 32'd0);
            chk("mid_rst_ack", ack[d], 32'd0);
            chk("mid_rst_err", err[d], 32'd0);
            chk("mid_rst_rdata", rdata[d], 32'd0);
            prev_rd[d] = 32'd0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h20, 32'h0);

        // Directed, LATENCY=1.
        txn(1, 1'b1, 32'h04, 32'hA5A5A5A5);
        txn(1, 1'b0, 32'h04, 32'h0);
        txn(1, 1'b0, 32'h07, 32'h0);
        txn(1, 1'b1, 32'h100, 32'h5);
        hold(1);

        // Random mix on both instances.
        for (int i = 0; i < 60; i++) begin
            int d;
            d = $urandom_range(0, 1);
            txn(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++) txn(d, 1'b0, 32'(w * 4), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_chk);
        $fatal(1, "timeout");
    end
endmodule
